// File: rtl/keypad_hex_entry_if.sv
// keypad_hex_entry_if: key strobe, selection handshake and status signals of the keypad entry stage.
`default_nettype none

interface keypad_hex_entry_if;
  logic       key_valid;
  logic [4:0] key_code;
  logic [3:0] hex_digit;
  logic [7:0] sel_code;
  logic       sel_valid;
  logic       sel_ready;
  logic       busy;
  logic       err;
  logic       timeout;

  modport master (
    output key_valid, key_code, sel_ready,
    input  hex_digit, sel_code, sel_valid, busy, err, timeout
  );

  modport slave (
    input  key_valid, key_code, sel_ready,
    output hex_digit, sel_code, sel_valid, busy, err, timeout
  );
endinterface

`default_nettype wire

// File: rtl/keypad_hex_entry.sv
// ---------------------------------------------------------------------------
// keypad_hex_entry : collects two hex keys into an 8-bit selection code
//                    and offers it downstream with a valid/ready handshake.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module keypad_hex_entry #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  keypad_hex_entry_if.slave   bus
);

  localparam int            CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [7:0]    code, code_n;
  logic [3:0]    digit, digit_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_n, tmo_n;
  logic          valid_q, err_q, tmo_q;

  logic is_digit, is_enter, is_clear;

  assign is_digit = bus.key_valid & ~bus.key_code[4];
  assign is_enter = bus.key_valid & (bus.key_code == 5'h10);
  assign is_clear = bus.key_valid & (bus.key_code == 5'h11);

  always_comb begin
    state_n = state;
    code_n  = code;
    digit_n = digit;
    cnt_n   = '0;
    err_n   = 1'b0;
    tmo_n   = 1'b0;
    case (state)
      IDLE: begin
        if (is_digit) begin
          code_n  = {code[3:0], bus.key_code[3:0]};
          digit_n = bus.key_code[3:0];
          state_n = ENTRY;
        end else if (is_clear) begin
          code_n  = '0;
          digit_n = '0;
        end else if (bus.key_valid) begin
          err_n = 1'b1;
        end
      end
      ENTRY, FULL: begin
        if (is_clear) begin
          state_n = IDLE;
          code_n  = '0;
          digit_n = '0;
        end else if (is_enter) begin
          state_n = HOLD;
        end else if (is_digit && state == ENTRY) begin
          code_n  = {code[3:0], bus.key_code[3:0]};
          digit_n = bus.key_code[3:0];
          state_n = FULL;
        end else if (bus.key_valid) begin
          // A rejected key neither restarts nor expires the idle window.
          err_n = 1'b1;
          cnt_n = cnt;
        end else if (cnt == TERM) begin
          state_n = IDLE;
          code_n  = '0;
          digit_n = '0;
          tmo_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (bus.sel_ready || is_clear) begin
          state_n = IDLE;
          code_n  = '0;
        end
        if (is_clear) begin
          digit_n = '0;
        end else if (bus.key_valid) begin
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      code    <= '0;
      digit   <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_n;
      code    <= code_n;
      digit   <= digit_n;
      cnt     <= cnt_n;
      valid_q <= (state_n == HOLD);
      err_q   <= err_n;
      tmo_q   <= tmo_n;
    end
  end

  assign bus.hex_digit = digit;
  assign bus.sel_code  = code;
  assign bus.sel_valid = valid_q;
  assign bus.err       = err_q;
  assign bus.timeout   = tmo_q;
  assign bus.busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry: directed sequence with a scoreboard of expected transferred selection codes.
`default_nettype none

module tb_keypad_hex_entry;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   hs    = 0;
  logic [7:0] sb[$];

  keypad_hex_entry_if bus();

  keypad_hex_entry #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 5'h00;
  endtask

  // A transfer happens at the next rising edge whenever valid and ready are both high here.
  always @(negedge clk) begin
    if (!rst && bus.sel_valid && bus.sel_ready) begin
      hs++;
      check("sb_pending", 8'(sb.size() != 0), 8'd1);
      if (sb.size() != 0) check("sb_code", bus.sel_code, sb.pop_front());
    end
  end

  initial begin
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'h00;
    bus.sel_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_code",  bus.sel_code,  8'h00);
    check("rst_hex",   bus.hex_digit, 8'h0);
    check("rst_valid", bus.sel_valid, 8'd0);
    check("rst_busy",  bus.busy,      8'd0);
    check("rst_err",   bus.err,       8'd0);
    check("rst_tmo",   bus.timeout,   8'd0);

    // Two digits, ready on the second offer cycle
    press(5'h0A);
    check("a5_busy", bus.busy, 8'd1);
    check("a5_hex1", bus.hex_digit, 8'hA);
    check("a5_code1", bus.sel_code, 8'h0A);
    press(5'h05);
    check("a5_code2", bus.sel_code, 8'hA5);
    check("a5_hex2", bus.hex_digit, 8'h5);
    sb.push_back(8'hA5);
    press(5'h10);
    check("a5_valid1", bus.sel_valid, 8'd1);
    check("a5_hold_code", bus.sel_code, 8'hA5);
    tick();
    check("a5_valid2", bus.sel_valid, 8'd1);
    bus.sel_ready = 1'b1;
    tick();
    bus.sel_ready = 1'b0;
    check("a5_valid_done", bus.sel_valid, 8'd0);
    check("a5_code_done", bus.sel_code, 8'h00);
    check("a5_busy_done", bus.busy, 8'd0);

    // One digit, ready held high throughout
    bus.sel_ready = 1'b1;
    press(5'h0F);
    sb.push_back(8'h0F);
    press(5'h10);
    check("0f_code", bus.sel_code, 8'h0F);
    check("0f_hex", bus.hex_digit, 8'hF);
    check("0f_valid", bus.sel_valid, 8'd1);
    tick();
    bus.sel_ready = 1'b0;
    check("0f_valid_done", bus.sel_valid, 8'd0);
    check("0f_busy_done", bus.busy, 8'd0);

    // Third digit rejected, then CLEAR
    press(5'h01);
    press(5'h02);
    press(5'h03);
    check("full_err", bus.err, 8'd1);
    check("full_code", bus.sel_code, 8'h12);
    tick();
    check("full_err_pulse", bus.err, 8'd0);
    press(5'h11);
    check("clr_code", bus.sel_code, 8'h00);
    check("clr_hex", bus.hex_digit, 8'h0);
    check("clr_busy", bus.busy, 8'd0);
    check("clr_err", bus.err, 8'd0);

    // Invalid command and ENTER in IDLE
    press(5'h1F);
    check("inv_err", bus.err, 8'd1);
    check("inv_busy", bus.busy, 8'd0);
    tick();
    press(5'h10);
    check("idle_enter_err", bus.err, 8'd1);
    check("idle_enter_valid", bus.sel_valid, 8'd0);
    tick();

    // Timeout 8 cycles after the accepted key
    press(5'h09);
    for (int i = 0; i < 7; i++) tick();
    check("tmo_early", bus.timeout, 8'd0);
    check("tmo_early_busy", bus.busy, 8'd1);
    tick();
    check("tmo_pulse", bus.timeout, 8'd1);
    check("tmo_code", bus.sel_code, 8'h00);
    check("tmo_hex", bus.hex_digit, 8'h0);
    check("tmo_busy", bus.busy, 8'd0);
    tick();
    check("tmo_pulse_end", bus.timeout, 8'd0);

    // A key in the expiry cycle wins and restarts the window
    press(5'h09);
    for (int i = 0; i < 7; i++) tick();
    press(5'h03);
    check("tmo_saved", bus.timeout, 8'd0);
    check("tmo_saved_code", bus.sel_code, 8'h93);
    for (int i = 0; i < 7; i++) tick();
    check("tmo2_early", bus.timeout, 8'd0);
    tick();
    check("tmo2_pulse", bus.timeout, 8'd1);
    tick();

    // Reset while offering discards the code
    press(5'h0C);
    press(5'h01);
    press(5'h10);
    check("c1_hold", bus.sel_code, 8'hC1);
    rst           = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 5'h05;
    tick();
    rst           = 1'b0;
    bus.key_valid = 1'b0;
    check("c1_rst_valid", bus.sel_valid, 8'd0);
    check("c1_rst_code", bus.sel_code, 8'h00);
    check("c1_rst_busy", bus.busy, 8'd0);
    press(5'h10);
    check("c1_enter_err", bus.err, 8'd1);
    check("c1_enter_busy", bus.busy, 8'd0);

    // CLEAR together with ready in HOLD
    press(5'h07);
    press(5'h10);
    sb.push_back(8'h07);
    bus.sel_ready = 1'b1;
    press(5'h11);
    bus.sel_ready = 1'b0;
    check("clr_rdy_err", bus.err, 8'd0);
    check("clr_rdy_valid", bus.sel_valid, 8'd0);
    check("clr_rdy_busy", bus.busy, 8'd0);

    // Digit in HOLD rejected, offer persists
    press(5'h04);
    press(5'h10);
    press(5'h06);
    check("hold_err", bus.err, 8'd1);
    check("hold_code", bus.sel_code, 8'h04);
    check("hold_valid", bus.sel_valid, 8'd1);
    press(5'h11);
    check("hold_clr_valid", bus.sel_valid, 8'd0);
    tick();

    check("sb_drained", 8'(sb.size()), 8'd0);
    check("hs_count", 8'(hs), 8'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
